// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB).
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   op, func        instr[31:26] / instr[5:0] from the datapath IR
//   zero            ALU equality flag, used by beq in EXEC
//   PCWrite, IRWrite, MemWrite, RegWrite   write strobes
//   RegDst, MemtoReg, npcsel, EXTop, ALUctr, ALUSrc   datapath selects
//   state           current FSM state
//   instr_done      one-cycle pulse on the final cycle of each instruction
//
// MEM_LAT (1..4) sets how many cycles each fetch and data access takes.
module mc_control #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] npcsel,
    output logic [1:0] EXTop,
    output logic [1:0] ALUctr,
    output logic       ALUSrc,
    output logic [2:0] state,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] LAST_WAIT = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pcw, irw, mw, rw, dn;

    // Instruction decode
    logic rtype, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal, i_unk;

    always_comb begin
        rtype  = (op == 6'b000000);
        i_addu = rtype && (func == 6'b100001);
        i_subu = rtype && (func == 6'b100011);
        i_jr   = rtype && (func == 6'b001000);
        i_ori  = (op == 6'b001101);
        i_lw   = (op == 6'b100011);
        i_sw   = (op == 6'b101011);
        i_beq  = (op == 6'b000100);
        i_lui  = (op == 6'b001111);
        i_j    = (op == 6'b000010);
        i_jal  = (op == 6'b000011);
        i_unk  = !(i_addu || i_subu || i_jr || i_ori || i_lw || i_sw ||
                   i_beq || i_lui || i_j || i_jal);
    end

    // Datapath selects depend only on the instruction, except npcsel which
    // is forced to PC+4 during FETCH.
    always_comb begin
        RegDst   = i_jal ? 2'b10 : (i_addu || i_subu) ? 2'b01 : 2'b00;
        MemtoReg = i_jal ? 2'b10 : i_lw ? 2'b01 : 2'b00;
        EXTop    = i_lui ? 2'b10 : (i_lw || i_sw || i_beq) ? 2'b01 : 2'b00;
        ALUctr   = i_ori ? 2'b10 : (i_subu || i_beq) ? 2'b01 : 2'b00;
        ALUSrc   = i_ori || i_lw || i_sw || i_lui;
        if (state_q == S_FETCH) npcsel = 2'b00;
        else if (i_jr)          npcsel = 2'b11;
        else if (i_j || i_jal)  npcsel = 2'b10;
        else if (i_beq)         npcsel = 2'b01;
        else                    npcsel = 2'b00;
    end

    // Next state and strobes
    always_comb begin
        state_d = S_FETCH;
        cnt_d   = 2'd0;
        pcw     = 1'b0;
        irw     = 1'b0;
        mw      = 1'b0;
        rw      = 1'b0;
        dn      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == LAST_WAIT) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (i_j || i_jr) begin
                    pcw = 1'b1;
                    dn  = 1'b1;
                end else if (i_jal) begin
                    pcw = 1'b1;
                    rw  = 1'b1;
                    dn  = 1'b1;
                end else if (i_unk) begin
                    dn  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (i_beq) begin
                    pcw = zero;
                    dn  = 1'b1;
                end else if (i_lw || i_sw) begin
                    state_d = S_MEM;
                end else if (i_addu || i_subu || i_ori || i_lui) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q == LAST_WAIT) begin
                    if (i_sw) begin
                        mw = 1'b1;
                        dn = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rw = 1'b1;
                dn = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked during reset so an aborted instruction never
    // commits a write in the cycle the reset edge lands on.
    always_comb begin
        PCWrite    = pcw && !reset;
        IRWrite    = irw && !reset;
        MemWrite   = mw  && !reset;
        RegWrite   = rw  && !reset;
        instr_done = dn  && !reset;
        state      = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
